// File: rtl/int_replay_pipe_buffer.sv
// rtl/int_replay_pipe_buffer.sv - issue replay shift buffer with flush kill, wake-fail stall select and occupancy
module int_replay_pipe_buffer #(
    parameter int LANES = 2,
    parameter int DEPTH = 2,
    parameter int PAY_W = 64,
    parameter int TAG_W = 6,
    localparam int SW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(LANES * DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_valid,
    input  logic [TAG_W-1:0]         flush_tag,
    input  logic [TAG_W-1:0]         rob_head,
    input  logic                     hold,
    input  logic                     wake_fail_stall,
    input  logic [SW-1:0]            wake_fail_stage,
    input  logic                     wake_predict_fail,
    input  logic                     dep_replay,
    input  logic [LANES-1:0]         issue_valid,
    input  logic [LANES-1:0]         issue_poison,
    input  logic [LANES*TAG_W-1:0]   issue_tag,
    input  logic [LANES*PAY_W-1:0]   issue_payload,
    output logic                     replay_first,
    output logic [LANES-1:0]         replay_valid,
    output logic [LANES*TAG_W-1:0]   replay_tag,
    output logic [LANES*PAY_W-1:0]   replay_payload,
    output logic [LANES-1:0]         stall_valid,
    output logic [LANES*TAG_W-1:0]   stall_tag,
    output logic [LANES*PAY_W-1:0]   stall_payload,
    output logic [CW-1:0]            occupancy
);

    localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

    logic             valid_q  [DEPTH][LANES];
    logic             poison_q [DEPTH][LANES];
    logic [TAG_W-1:0] tag_q    [DEPTH][LANES];
    logic [PAY_W-1:0] pay_q    [DEPTH][LANES];
    logic             kill     [DEPTH][LANES];
    logic [SW-1:0]    sel_q;
    logic [SW-1:0]    sel_d;
    logic [TAG_W-1:0] flush_age;
    logic [TAG_W-1:0] entry_age;

    // Ages are taken relative to the ROB head so tag wrap-around compares correctly.
    always_comb begin
        flush_age = flush_tag - rob_head;
        entry_age = '0;
        for (int d = 0; d < DEPTH; d++) begin
            for (int l = 0; l < LANES; l++) begin
                entry_age  = tag_q[d][l] - rob_head;
                kill[d][l] = flush_valid && (entry_age > flush_age);
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (wake_predict_fail) begin
            sel_d = LAST;
        end else if (flush_valid) begin
            sel_d = sel_q;
        end else if (wake_fail_stall) begin
            if (int'(wake_fail_stage) >= DEPTH) begin
                sel_d = LAST;
            end else begin
                sel_d = wake_fail_stage;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int l = 0; l < LANES; l++) begin
                    valid_q[d][l]  <= 1'b0;
                    poison_q[d][l] <= 1'b0;
                    tag_q[d][l]    <= '0;
                    pay_q[d][l]    <= '0;
                end
            end
            sel_q <= LAST;
        end else begin
            if (flush_valid || hold) begin
                for (int d = 0; d < DEPTH; d++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (kill[d][l]) begin
                            valid_q[d][l] <= 1'b0;
                        end
                    end
                end
            end else if (wake_fail_stall) begin
                for (int d = 0; d < DEPTH; d++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if ((SW'(d) == sel_q) && !poison_q[d][l]) begin
                            valid_q[d][l] <= 1'b0;
                        end
                    end
                end
            end else begin
                // Stage 0 takes the new issue group unless the group is being dropped.
                for (int l = 0; l < LANES; l++) begin
                    if (dep_replay) begin
                        valid_q[0][l] <= 1'b0;
                    end else begin
                        valid_q[0][l]  <= issue_valid[l];
                        poison_q[0][l] <= issue_poison[l];
                        tag_q[0][l]    <= issue_tag[l*TAG_W +: TAG_W];
                        pay_q[0][l]    <= issue_payload[l*PAY_W +: PAY_W];
                    end
                    for (int d = 1; d < DEPTH; d++) begin
                        valid_q[d][l]  <= valid_q[d-1][l];
                        poison_q[d][l] <= poison_q[d-1][l];
                        tag_q[d][l]    <= tag_q[d-1][l];
                        pay_q[d][l]    <= pay_q[d-1][l];
                    end
                end
            end
            sel_q <= sel_d;
        end
    end

    always_comb begin
        replay_valid   = '0;
        replay_tag     = '0;
        replay_payload = '0;
        stall_valid    = '0;
        stall_tag      = '0;
        stall_payload  = '0;
        for (int l = 0; l < LANES; l++) begin
            replay_valid[l]                  = valid_q[DEPTH-1][l];
            replay_tag[l*TAG_W +: TAG_W]     = tag_q[DEPTH-1][l];
            replay_payload[l*PAY_W +: PAY_W] = pay_q[DEPTH-1][l];
            for (int d = 0; d < DEPTH; d++) begin
                if (SW'(d) == sel_q) begin
                    stall_valid[l]                  = valid_q[d][l] && !poison_q[d][l];
                    stall_tag[l*TAG_W +: TAG_W]     = tag_q[d][l];
                    stall_payload[l*PAY_W +: PAY_W] = pay_q[d][l];
                end
            end
        end
    end

    always_comb begin
        occupancy    = '0;
        replay_first = 1'b0;
        for (int d = 0; d < DEPTH; d++) begin
            for (int l = 0; l < LANES; l++) begin
                occupancy    = occupancy + CW'(valid_q[d][l] && !poison_q[d][l]);
                replay_first = replay_first | (valid_q[d][l] && !poison_q[d][l]);
            end
        end
    end

endmodule
